// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder slice, LSB-first, one bit per clock.
// Latency: start accepted at edge k -> busy for WIDTH cycles -> done pulse after edge k+WIDTH.
// Backpressure: none; start is sampled only in IDLE/DONE and ignored while RUN.
// Optional feature macro: SERIAL_OVF_EN adds the signed-overflow output ovf.
module serial_addsub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
`ifdef SERIAL_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             opr_q, opr_d;
    logic             c_q, c_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Adder slice signals for the bit currently at the bottom of the shift regs
    logic e_bit, s_bit, c_nxt, last_bit;

    // Next-state, slice arithmetic and registered-output computation
    always_comb begin
        e_bit    = sb_q[0] ^ opr_q;
        s_bit    = sa_q[0] ^ e_bit ^ c_q;
        c_nxt    = (sa_q[0] & e_bit) | (c_q & (sa_q[0] ^ e_bit));
        last_bit = (cnt_q == CW'(WIDTH - 1));

        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        opr_d   = opr_q;
        c_d     = c_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        cout_d  = cout_q;
`ifdef SERIAL_OVF_EN
        ovf_d   = ovf_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    // Result is deliberately not cleared: it holds until the first shift
                    state_d = S_RUN;
                    sa_d    = a;
                    sb_d    = b;
                    opr_d   = op;
                    c_d     = op;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
`ifdef SERIAL_OVF_EN
                    ovf_d   = 1'b0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                res_d = {s_bit, res_q[WIDTH-1:1]};
                c_d   = c_nxt;
                cnt_d = cnt_q + CW'(1);
                if (last_bit) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    cout_d  = c_nxt;
`ifdef SERIAL_OVF_EN
                    // c_q is the carry into the MSB slice on this cycle
                    ovf_d   = c_q ^ c_nxt;
`endif
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            opr_q   <= 1'b0;
            c_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SERIAL_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            opr_q   <= opr_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cout_q  <= cout_d;
`ifdef SERIAL_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = res_q;
    assign cout   = cout_q;
`ifdef SERIAL_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule
